// File: rtl/glitch_pkg.sv
// Shared types and default sizing for the glitch sweep controller.
// The FSM encoding and timeout preload helper live here so the top and any sub-blocks agree.
package glitch_pkg;

    localparam int unsigned DLY_W_DEF   = 32;
    localparam int unsigned WID_W_DEF   = 16;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam logic [31:0] TIMEOUT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_DONE,
        RELEASE,
        COOLDOWN,
        NEXT,
        FINISH
    } state_e;

    // The timer is loaded on the trigger edge, so the preload is one less than the wait length.
    function automatic logic [31:0] timeout_load(input logic [31:0] timeout);
        return (timeout > 32'd1) ? timeout - 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter with a terminal flag; sticks at zero until reloaded.
// Shared by the cooldown and engine-timeout paths of the sweep controller.
module cyc_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: reset is sampled on the clock edge and state updates use <=, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Sweeps glitch delay over a latched range, triggering the glitch engine a fixed number of
// times per point and stopping on the first target compromise, engine timeout or range end.
module glitch_sweep_ctrl
    import glitch_pkg::*;
#(
    parameter int unsigned DLY_W   = DLY_W_DEF,
    parameter int unsigned WID_W   = WID_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter logic [31:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DLY_W-1:0] cfg_dly_start,
    input  logic [DLY_W-1:0] cfg_dly_end,
    input  logic [DLY_W-1:0] cfg_dly_step,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_tries,
    input  logic [CNT_W-1:0] cfg_cooldown,
    output logic [DLY_W-1:0] eng_dly,
    output logic [WID_W-1:0] eng_width,
    output logic             eng_trigger,
    input  logic             eng_done,
    input  logic             tgt_ok,
    output logic             busy,
    output logic             finished,
    output logic             hit,
    output logic             timeout_err,
    output logic [DLY_W-1:0] hit_dly,
    output logic [31:0]      attempts
);

    localparam logic [31:0] TO_LOAD = timeout_load(TIMEOUT);

    state_e           state_q,       state_d;
    logic [DLY_W-1:0] cur_dly_q,     cur_dly_d;
    logic [CNT_W-1:0] try_q,         try_d;
    logic [DLY_W-1:0] dly_end_q,     dly_end_d;
    logic [DLY_W-1:0] dly_step_q,    dly_step_d;
    logic [WID_W-1:0] width_q,       width_d;
    logic [CNT_W-1:0] tries_q,       tries_d;
    logic [CNT_W-1:0] cooldown_q,    cooldown_d;
    logic [DLY_W-1:0] eng_dly_q,     eng_dly_d;
    logic [WID_W-1:0] eng_width_q,   eng_width_d;
    logic             trig_q,        trig_d;
    logic             busy_q,        busy_d;
    logic             finished_q,    finished_d;
    logic             hit_q,         hit_d;
    logic             timeout_err_q, timeout_err_d;
    logic [DLY_W-1:0] hit_dly_q,     hit_dly_d;
    logic [31:0]      attempts_q,    attempts_d;

    logic             cd_load;
    logic             cd_done;
    logic             to_load;
    logic             to_done;

    logic [DLY_W:0]   dly_sum;
    logic [CNT_W-1:0] tries_eff;
    logic [CNT_W-1:0] try_inc;
    logic             sweep_done;

    cyc_timer #(.W(CNT_W)) u_cooldown (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cd_load),
        .load_val_i (cooldown_q),
        .done_o     (cd_done)
    );

    cyc_timer #(.W(32)) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .done_o     (to_done)
    );

    // The extra carry bit catches wrap-around past the top of the delay range.
    assign dly_sum    = {1'b0, cur_dly_q} + {1'b0, dly_step_q};
    assign sweep_done = dly_sum[DLY_W] || (dly_sum > {1'b0, dly_end_q}) || (dly_step_q == '0);
    assign tries_eff  = (tries_q == '0) ? CNT_W'(1) : tries_q;
    assign try_inc    = try_q + CNT_W'(1);

    // NOTE: every _d is given its hold value first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cur_dly_d     = cur_dly_q;
        try_d         = try_q;
        dly_end_d     = dly_end_q;
        dly_step_d    = dly_step_q;
        width_d       = width_q;
        tries_d       = tries_q;
        cooldown_d    = cooldown_q;
        finished_d    = finished_q;
        hit_d         = hit_q;
        timeout_err_d = timeout_err_q;
        hit_dly_d     = hit_dly_q;
        attempts_d    = attempts_q;
        cd_load       = 1'b0;

        if (state_q == ARM) begin
            attempts_d = attempts_q + 32'd1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            finished_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        dly_end_d     = cfg_dly_end;
                        dly_step_d    = cfg_dly_step;
                        width_d       = cfg_width;
                        tries_d       = cfg_tries;
                        cooldown_d    = cfg_cooldown;
                        cur_dly_d     = cfg_dly_start;
                        try_d         = '0;
                        finished_d    = 1'b0;
                        hit_d         = 1'b0;
                        timeout_err_d = 1'b0;
                        hit_dly_d     = '0;
                        attempts_d    = '0;
                        state_d       = (cfg_dly_start > cfg_dly_end) ? FINISH : ARM;
                    end
                end
                ARM: begin
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        state_d = RELEASE;
                    end else if (to_done) begin
                        timeout_err_d = 1'b1;
                        state_d       = FINISH;
                    end
                end
                RELEASE: begin
                    if (!eng_done) begin
                        cd_load = 1'b1;
                        state_d = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cd_done) begin
                        if (tgt_ok) begin
                            hit_d     = 1'b1;
                            hit_dly_d = cur_dly_q;
                            state_d   = FINISH;
                        end else begin
                            state_d = NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (try_inc < tries_eff) begin
                        try_d   = try_inc;
                        state_d = ARM;
                    end else if (sweep_done) begin
                        try_d   = '0;
                        state_d = FINISH;
                    end else begin
                        try_d     = '0;
                        cur_dly_d = dly_sum[DLY_W-1:0];
                        state_d   = ARM;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == FINISH) begin
            finished_d = 1'b1;
        end

        // Outputs are decoded from the next state so they leave a flop, never a gate.
        trig_d      = (state_d == ARM) || (state_d == WAIT_DONE);
        busy_d      = (state_d != IDLE) && (state_d != FINISH);
        to_load     = (state_d == ARM);
        eng_dly_d   = (state_d == ARM) ? cur_dly_d : eng_dly_q;
        eng_width_d = (state_d == ARM) ? width_d   : eng_width_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_dly_q     <= '0;
            try_q         <= '0;
            dly_end_q     <= '0;
            dly_step_q    <= '0;
            width_q       <= '0;
            tries_q       <= '0;
            cooldown_q    <= '0;
            eng_dly_q     <= '0;
            eng_width_q   <= '0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            hit_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            hit_dly_q     <= '0;
            attempts_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_dly_q     <= cur_dly_d;
            try_q         <= try_d;
            dly_end_q     <= dly_end_d;
            dly_step_q    <= dly_step_d;
            width_q       <= width_d;
            tries_q       <= tries_d;
            cooldown_q    <= cooldown_d;
            eng_dly_q     <= eng_dly_d;
            eng_width_q   <= eng_width_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            hit_q         <= hit_d;
            timeout_err_q <= timeout_err_d;
            hit_dly_q     <= hit_dly_d;
            attempts_q    <= attempts_d;
        end
    end

    assign eng_dly     = eng_dly_q;
    assign eng_width   = eng_width_q;
    assign eng_trigger = trig_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign hit         = hit_q;
    assign timeout_err = timeout_err_q;
    assign hit_dly     = hit_dly_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl: expected engine delays are queued per sweep and
// popped on every trigger rising edge; status is checked at fixed points.
module tb_glitch_sweep_ctrl;

    localparam int unsigned DLY_W   = 32;
    localparam int unsigned WID_W   = 16;
    localparam int unsigned CNT_W   = 8;
    localparam logic [31:0] TIMEOUT = 32'd100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [DLY_W-1:0] cfg_dly_start;
    logic [DLY_W-1:0] cfg_dly_end;
    logic [DLY_W-1:0] cfg_dly_step;
    logic [WID_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_tries;
    logic [CNT_W-1:0] cfg_cooldown;
    logic [DLY_W-1:0] eng_dly;
    logic [WID_W-1:0] eng_width;
    logic             eng_trigger;
    logic             eng_done;
    logic             tgt_ok;
    logic             busy;
    logic             finished;
    logic             hit;
    logic             timeout_err;
    logic [DLY_W-1:0] hit_dly;
    logic [31:0]      attempts;

    always #5 clk = ~clk;

    glitch_sweep_ctrl #(
        .DLY_W   (DLY_W),
        .WID_W   (WID_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_dly_start (cfg_dly_start),
        .cfg_dly_end   (cfg_dly_end),
        .cfg_dly_step  (cfg_dly_step),
        .cfg_width     (cfg_width),
        .cfg_tries     (cfg_tries),
        .cfg_cooldown  (cfg_cooldown),
        .eng_dly       (eng_dly),
        .eng_width     (eng_width),
        .eng_trigger   (eng_trigger),
        .eng_done      (eng_done),
        .tgt_ok        (tgt_ok),
        .busy          (busy),
        .finished      (finished),
        .hit           (hit),
        .timeout_err   (timeout_err),
        .hit_dly       (hit_dly),
        .attempts      (attempts)
    );

    typedef struct packed {
        logic [DLY_W-1:0] dly;
        logic [WID_W-1:0] width;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   trig_count = 0;
    logic trig_prev  = 1'b0;
    logic eng_auto   = 1'b0;
    logic hit_mode   = 1'b0;
    int   hit_base   = 0;
    int   base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DLY_W-1:0] dly, input logic [WID_W-1:0] width);
        exp_t e;
        e.dly   = dly;
        e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [DLY_W-1:0] s, input logic [DLY_W-1:0] e,
                           input logic [DLY_W-1:0] st, input logic [CNT_W-1:0] tr,
                           input logic [CNT_W-1:0] cd, input logic [WID_W-1:0] w);
        cfg_dly_start = s;
        cfg_dly_end   = e;
        cfg_dly_step  = st;
        cfg_tries     = tr;
        cfg_cooldown  = cd;
        cfg_width     = w;
    endtask

    // Returns at the falling edge just after the edge that accepted start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int budget);
        int n;
        n = 0;
        while (finished !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eng_dly"},     64'(eng_dly),     64'd0);
        check({tag, "_eng_width"},   64'(eng_width),   64'd0);
        check({tag, "_eng_trigger"}, 64'(eng_trigger), 64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_finished"},    64'(finished),    64'd0);
        check({tag, "_hit"},         64'(hit),         64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_hit_dly"},     64'(hit_dly),     64'd0);
        check({tag, "_attempts"},    64'(attempts),    64'd0);
    endtask

    // Engine and target model: done follows trigger, target reports compromise after the third trigger.
    initial begin
        eng_done = 1'b0;
        tgt_ok   = 1'b0;
        forever begin
            @(negedge clk);
            eng_done = eng_auto && eng_trigger;
            tgt_ok   = hit_mode && ((trig_count - hit_base) >= 3) && !eng_trigger;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (eng_trigger && !trig_prev) begin
            trig_count++;
            check("trigger_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("eng_dly", 64'(eng_dly), 64'(e.dly));
                check("eng_width", 64'(eng_width), 64'(e.width));
            end
        end
        trig_prev = eng_trigger;
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(32'd0, 32'd0, 32'd0, 8'd0, 8'd0, 16'd0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Full sweep without a hit; config is scrambled after start to prove it was latched.
        eng_auto = 1'b1;
        set_cfg(32'd5, 32'd15, 32'd5, 8'd2, 8'd2, 16'h0007);
        push_exp(32'd5, 16'h0007);
        push_exp(32'd5, 16'h0007);
        push_exp(32'd10, 16'h0007);
        push_exp(32'd10, 16'h0007);
        push_exp(32'd15, 16'h0007);
        push_exp(32'd15, 16'h0007);
        pulse_start();
        check("sweep_busy", 64'(busy), 64'd1);
        set_cfg(32'd0, 32'd1000, 32'd1, 8'd5, 8'd0, 16'h0099);
        wait_finished("sweep", 500);
        check("sweep_attempts", 64'(attempts), 64'd6);
        check("sweep_hit", 64'(hit), 64'd0);
        check("sweep_busy_end", 64'(busy), 64'd0);
        check("sweep_queue", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("sweep_finished_hold", 64'(finished), 64'd1);

        // Hit during the third cooldown stops the sweep.
        set_cfg(32'd5, 32'd15, 32'd5, 8'd2, 8'd2, 16'h0007);
        hit_base = trig_count;
        hit_mode = 1'b1;
        push_exp(32'd5, 16'h0007);
        push_exp(32'd5, 16'h0007);
        push_exp(32'd10, 16'h0007);
        pulse_start();
        check("hit_finished_cleared", 64'(finished), 64'd0);
        wait_finished("hit", 500);
        check("hit_flag", 64'(hit), 64'd1);
        check("hit_dly", 64'(hit_dly), 64'd10);
        check("hit_attempts", 64'(attempts), 64'd3);
        repeat (20) @(negedge clk);
        check("hit_trigger_count", 64'(trig_count - hit_base), 64'd3);
        hit_mode = 1'b0;

        // Empty range finishes immediately with no trigger.
        set_cfg(32'd20, 32'd10, 32'd5, 8'd2, 8'd2, 16'h0007);
        base = trig_count;
        pulse_start();
        check("empty_finished", 64'(finished), 64'd1);
        check("empty_attempts", 64'(attempts), 64'd0);
        check("empty_hit_cleared", 64'(hit), 64'd0);
        check("empty_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("empty_no_trigger", 64'(trig_count - base), 64'd0);

        // Engine never answers: timeout exactly 100 cycles after the trigger edge.
        eng_auto = 1'b0;
        set_cfg(32'd5, 32'd15, 32'd5, 8'd1, 8'd2, 16'h0007);
        push_exp(32'd5, 16'h0007);
        pulse_start();
        check("to_trigger_high", 64'(eng_trigger), 64'd1);
        repeat (99) @(negedge clk);
        check("to_not_yet", 64'(timeout_err), 64'd0);
        @(negedge clk);
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_trigger_low", 64'(eng_trigger), 64'd0);
        check("to_finished", 64'(finished), 64'd1);
        check("to_attempts", 64'(attempts), 64'd1);

        // Abort while waiting on the engine.
        set_cfg(32'd5, 32'd15, 32'd5, 8'd2, 8'd2, 16'h0007);
        push_exp(32'd5, 16'h0007);
        pulse_start();
        repeat (3) @(negedge clk);
        check("abort_pre_trigger", 64'(eng_trigger), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_trigger", 64'(eng_trigger), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_finished", 64'(finished), 64'd0);
        check("abort_attempts", 64'(attempts), 64'd1);

        // Start and abort together in IDLE: abort wins.
        base = trig_count;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("start_abort_no_trigger", 64'(trig_count - base), 64'd0);

        // Reset while the trigger is high drops it on the same edge.
        push_exp(32'd5, 16'h0007);
        pulse_start();
        repeat (2) @(negedge clk);
        check("rst_wait_trigger_high", 64'(eng_trigger), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait_trigger_low", 64'(eng_trigger), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a long cooldown clears everything.
        eng_auto = 1'b1;
        set_cfg(32'd5, 32'd15, 32'd5, 8'd1, 8'd200, 16'h0007);
        push_exp(32'd5, 16'h0007);
        pulse_start();
        repeat (8) @(negedge clk);
        check("cool_busy", 64'(busy), 64'd1);
        check("cool_attempts", 64'(attempts), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_cooldown");
        rst_n = 1'b1;

        // Delay sum overflows past the top of the range after one point.
        set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd16, 8'd1, 8'd2, 16'h0007);
        push_exp(32'hFFFF_FFF0, 16'h0007);
        pulse_start();
        wait_finished("ovf", 200);
        check("ovf_attempts", 64'(attempts), 64'd1);
        check("ovf_hit", 64'(hit), 64'd0);

        // Zero step and zero tries: exactly one attempt, zero cooldown.
        set_cfg(32'd3, 32'd9, 32'd0, 8'd0, 8'd0, 16'h0007);
        push_exp(32'd3, 16'h0007);
        pulse_start();
        wait_finished("step0", 200);
        check("step0_attempts", 64'(attempts), 64'd1);

        repeat (5) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
